// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: PC fetch requests in, instruction/PC/fault out over valid/ready.
// Define IMEM_PERF_CNT_EN to add the perf_req_cnt / perf_stall_cnt counters.
//
// state  | meaning
// IDLE   | ready for a fetch request (req_ready=1 unless flushing)
// WAIT   | request accepted, burning wait states
// RESP   | response presented, waiting for rsp_ready
module imem_fetch_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic [31:0] rsp_pc,
  output logic        rsp_fault,
  input  logic        init_we,
  input  logic [31:0] init_addr,
  input  logic [31:0] init_data
`ifdef IMEM_PERF_CNT_EN
  ,
  output logic [31:0] perf_req_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_pc_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        load_rsp;
  logic [31:0] rd_pc;
  logic        rd_fault;
  logic        init_in_range;
  logic        unused_init_lsb;

  assign req_ready = rst && (state_q == S_IDLE) && !flush;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == S_RESP);

  // With zero wait states the read happens on the accept edge, before pend_pc_q is loaded.
  assign rd_pc    = (state_q == S_IDLE) ? req_addr : pend_pc_q;
  assign rd_fault = (rd_pc[1:0] != 2'b00) || ((rd_pc >> (AW + 2)) != 32'd0);
  assign load_rsp = (state_d == S_RESP) && (state_q != S_RESP);

  assign init_in_range   = ((init_addr >> (AW + 2)) == 32'd0);
  assign unused_init_lsb = ^init_addr[1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (WAIT_STATES == 0) begin
              state_d = S_RESP;
            end else begin
              state_d = S_WAIT;
              cnt_d   = CNT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) state_d = S_RESP;
          else               cnt_d   = cnt_q - 4'd1;
        end
        S_RESP: begin
          if (rsp_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      pend_pc_q <= 32'd0;
      rsp_instr <= 32'd0;
      rsp_pc    <= 32'd0;
      rsp_fault <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) pend_pc_q <= req_addr;
      if (load_rsp) begin
        rsp_pc    <= rd_pc;
        rsp_fault <= rd_fault;
        rsp_instr <= rd_fault ? NOP_INSTR : mem[rd_pc[AW+1:2]];
      end
    end
  end

  // Store is not reset; a same-edge write is seen only by later reads.
  always_ff @(posedge clk) begin
    if (init_we && init_in_range) mem[init_addr[AW+1:2]] <= init_data;
  end

`ifdef IMEM_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_req_cnt   <= 32'd0;
      perf_stall_cnt <= 32'd0;
    end else begin
      if (accept) perf_req_cnt <= perf_req_cnt + 32'd1;
      if (rsp_valid && !rsp_ready && !flush) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Scoreboard bench for imem_fetch_responder (DEPTH_WORDS=1024, WAIT_STATES=1).
module tb_imem_fetch_responder;

  localparam int WS = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, flush;
  logic [31:0] req_addr;
  logic        rsp_valid, rsp_ready, rsp_fault;
  logic [31:0] rsp_instr, rsp_pc;
  logic        init_we;
  logic [31:0] init_addr, init_data;
`ifdef IMEM_PERF_CNT_EN
  logic [31:0] perf_req_cnt, perf_stall_cnt;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  imem_fetch_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(WS), .NOP_INSTR(32'h00000013)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .flush(flush),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr), .rsp_pc(rsp_pc), .rsp_fault(rsp_fault),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
`ifdef IMEM_PERF_CNT_EN
    , .perf_req_cnt(perf_req_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, got, want);
    end
  endtask

  // Monitor: every handshake must match the oldest expected response.
  always @(negedge clk) begin
    if (rst === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1 && flush === 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp_pc", rsp_pc, 32'hxxxxxxxx);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_instr", rsp_instr, e.instr);
        chk("rsp_pc", rsp_pc, e.pc);
        chk("rsp_fault", {31'd0, rsp_fault}, {31'd0, e.fault});
      end
    end
  end

  task automatic init_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    init_we = 1'b1; init_addr = a; init_data = d;
    @(posedge clk); #1;
    init_we = 1'b0;
  endtask

  // Issue one fetch; optionally hold rsp_ready low for `hold` cycles, or write the
  // same word in flight so that it lands on the read edge.
  task automatic do_fetch(input logic [31:0] a, input logic [31:0] ei, input logic ef,
                          input int hold, input logic wr_en, input logic [31:0] wr_data);
    int n;
    logic [31:0] s_instr, s_pc;
    exp_q.push_back('{instr: ei, pc: a, fault: ef});
    @(posedge clk); #1;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    rsp_ready = (hold == 0);
    req_valid = 1'b1; req_addr = a;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (wr_en) begin
      init_we = 1'b1; init_addr = a; init_data = wr_data;
    end
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (rsp_valid) break;
    end
    init_we = 1'b0;
    chk("latency", n, WS + 1);
    s_instr = rsp_instr;
    s_pc    = rsp_pc;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_instr", rsp_instr, s_instr);
      chk("bp_pc", rsp_pc, s_pc);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
`ifdef IMEM_PERF_CNT_EN
    if (hold > 0) chk("perf_stall_cnt", perf_stall_cnt, hold);
`endif
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("req_ready_after_hs", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_addr = 32'd0; flush = 1'b0;
    rsp_ready = 1'b1; init_we = 1'b0; init_addr = 32'd0; init_data = 32'd0;
    #12;
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_req_ready", {31'd0, req_ready}, 32'd0);
    chk("reset_rsp_instr", rsp_instr, 32'd0);
    chk("reset_rsp_pc", rsp_pc, 32'd0);
    chk("reset_rsp_fault", {31'd0, rsp_fault}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    init_write(32'h0, 32'h11111111);
    init_write(32'h4, 32'h22222222);
    init_write(32'h8, 32'h33333333);
    init_write(32'hC, 32'h44444444);
    init_write(32'hFFC, 32'h5A5A0FFC);
    init_write(32'h1000, 32'hDEADBEEF);  // out of range: must not alias word 0

    do_fetch(32'h4, 32'h22222222, 1'b0, 0, 1'b0, 32'd0);
    do_fetch(32'h6, 32'h00000013, 1'b1, 0, 1'b0, 32'd0);
    do_fetch(32'h1000, 32'h00000013, 1'b1, 0, 1'b0, 32'd0);
    do_fetch(32'hFFC, 32'h5A5A0FFC, 1'b0, 0, 1'b0, 32'd0);
    do_fetch(32'h0, 32'h11111111, 1'b0, 5, 1'b0, 32'd0);
    do_fetch(32'h8, 32'h33333333, 1'b0, 0, 1'b1, 32'hAAAA5555);
    do_fetch(32'h8, 32'hAAAA5555, 1'b0, 0, 1'b0, 32'd0);

    // Flush one cycle after accept, then try to fetch while flushing in IDLE.
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h8;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_valid", {31'd0, rsp_valid}, 32'd0);
    req_valid = 1'b1; req_addr = 32'hC;
    chk("flush_req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_flush_valid", {31'd0, rsp_valid}, 32'd0);
    end
    do_fetch(32'hC, 32'h44444444, 1'b0, 0, 1'b0, 32'd0);

    // Flush while presenting a stalled response.
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h4;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("resp_before_flush", {31'd0, rsp_valid}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("resp_flushed", {31'd0, rsp_valid}, 32'd0);
    rsp_ready = 1'b1;
`ifdef IMEM_PERF_CNT_EN
    chk("perf_stall_after_flush", perf_stall_cnt, 32'd5);
`endif

    // Reset during WAIT.
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h4;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_wait_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_wait_instr", rsp_instr, 32'd0);
    chk("rst_wait_pc", rsp_pc, 32'd0);
    chk("rst_wait_fault", {31'd0, rsp_fault}, 32'd0);
    chk("rst_wait_req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
    end
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    do_fetch(32'h4, 32'h22222222, 1'b0, 0, 1'b0, 32'd0);
`ifdef IMEM_PERF_CNT_EN
    chk("perf_req_cnt", perf_req_cnt, 32'd1);
`endif

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
